// File: rtl/trace_halt_ctrl.sv
// Run/halt controller for a CPU under test: counts RUN cycles, detects halt
// conditions, and buffers every retired {pc, instr} in a trace FIFO for draining.
module trace_halt_ctrl #(
  parameter int              XLEN       = 32,
  parameter int              DEPTH      = 16,
  parameter int              MAX_CYCLES = 100000,
  parameter logic [XLEN-1:0] HALT_PC    = 32'hfffffffc,
  parameter int              LOOP_LIMIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            retire,
  input  logic [XLEN-1:0] pc_in,
  input  logic [31:0]     instr_in,
  output logic            halt,
  output logic [2:0]      halt_cause,
  output logic            done,
  output logic [31:0]     cycle_cnt,
  output logic            trace_vld,
  input  logic            trace_rdy,
  output logic [XLEN-1:0] trace_pc,
  output logic [31:0]     trace_instr,
  output logic            trace_ovf
);

  localparam int              AW        = $clog2(DEPTH);
  localparam int              CW        = AW + 1;
  localparam int              EW        = XLEN + 32;
  localparam logic [AW-1:0]   PTR_ONE   = AW'(1);
  localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
  localparam logic [CW-1:0]   CNT_FULL  = CW'(DEPTH);
  localparam logic [31:0]     CYC_LAST  = 32'(MAX_CYCLES - 1);
  localparam logic [31:0]     LOOP_LAST = 32'(LOOP_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_halt;
  logic            r_done;
  logic [31:0]     r_cycle_cnt;
  logic [2:0]      r_cause;
  logic            r_ovf;
  logic [31:0]     r_loop_cnt;
  logic            r_first;
  logic [XLEN-1:0] r_last_pc;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [EW-1:0]   r_mem [DEPTH];

  logic            w_start_run;
  logic            w_in_run;
  logic            w_push;
  logic            w_pop;
  logic            w_vld;
  logic            w_full;
  logic            w_wr_en;
  logic            w_same_pc;
  logic            w_cyc_hit;
  logic            w_pc_hit;
  logic            w_loop_hit;
  logic [2:0]      w_cause_set;

  assign w_start_run = start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_in_run    = (r_state == S_RUN);
  assign w_vld       = (r_count != '0);
  assign w_full      = (r_count == CNT_FULL);
  assign w_push      = w_in_run && retire;
  assign w_pop       = w_vld && trace_rdy;
  assign w_wr_en     = w_push && (!w_full || w_pop);

  // The first retire of a run never matches the previous run's last PC.
  assign w_same_pc   = !r_first && (pc_in == r_last_pc);
  assign w_cyc_hit   = w_in_run && (r_cycle_cnt == CYC_LAST);
  assign w_pc_hit    = w_push && (pc_in == HALT_PC);
  assign w_loop_hit  = w_push && w_same_pc && (r_loop_cnt == LOOP_LAST);
  assign w_cause_set = {w_loop_hit, w_pc_hit, w_cyc_hit};

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (|w_cause_set) w_state_next = S_DRAIN;
      S_DRAIN: if (!w_vld) w_state_next = S_DONE;
      S_DONE:  if (start) w_state_next = S_RUN;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_halt  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_halt  <= (w_state_next == S_DRAIN) || (w_state_next == S_DONE);
      r_done  <= (w_state_next == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cycle_cnt <= '0;
      r_cause     <= '0;
      r_loop_cnt  <= '0;
      r_first     <= 1'b1;
      r_last_pc   <= '0;
    end else if (w_start_run) begin
      r_cycle_cnt <= '0;
      r_cause     <= '0;
      r_loop_cnt  <= '0;
      r_first     <= 1'b1;
    end else begin
      if (w_in_run) begin
        r_cycle_cnt <= r_cycle_cnt + 32'd1;
        r_cause     <= r_cause | w_cause_set;
      end
      if (w_push) begin
        r_last_pc  <= pc_in;
        r_first    <= 1'b0;
        r_loop_cnt <= w_same_pc ? (r_loop_cnt + 32'd1) : 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else if (w_start_run) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_wr_en, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is governed entirely by the count.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= {pc_in, instr_in};
  end

  assign {trace_pc, trace_instr} = r_mem[r_rd_ptr];
  assign trace_vld  = w_vld;
  assign trace_ovf  = r_ovf;
  assign halt       = r_halt;
  assign done       = r_done;
  assign halt_cause = r_cause;
  assign cycle_cnt  = r_cycle_cnt;

endmodule
